// File: rtl/drain_sequencer.sv
// drain_sequencer: cycle-exact drain sequencer for the systolic array result path.
// Optional DRAIN_SEQ_AUTO_CLEAR_EN: pulse acc_clear together with done.
module drain_sequencer #(
    parameter int N       = 4,
    parameter int AW      = 16,
    parameter int PPU_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          start,
    input  logic [AW-1:0]                 base_addr,
    input  logic [AW-1:0]                 addr_stride,
    output logic                          busy,
    output logic                          done,
    output logic                          start_err,
    output logic                          drain_enable,
    output logic                          ppu_capture_en,
    output logic [(N>1?$clog2(N):1)-1:0]  ppu_cycle_idx,
    output logic                          ub_wr_en,
    output logic [AW-1:0]                 ub_wr_addr,
    output logic                          acc_clear
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(N + PPU_LAT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [PPU_LAT-1:0]  hist, hist_n;
    logic [AW-1:0]       stride, stride_n, ptr, ptr_n, addr_n;
    logic [IW-1:0]       idx_n;
    logic                cap_n, wr_n, drain_n, done_n, last;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stride_n = stride;
        ptr_n    = ptr;
        idx_n    = ppu_cycle_idx;
        addr_n   = ub_wr_addr;
        cap_n    = 1'b0;
        wr_n     = 1'b0;
        drain_n  = 1'b0;
        done_n   = 1'b0;
        last     = cnt == CW'(N + PPU_LAT - 1);
        case (state)
            IDLE: if (start) begin
                state_n  = DRAIN;
                cnt_n    = '0;
                stride_n = addr_stride;
                ptr_n    = base_addr;
                cap_n    = 1'b1;
                idx_n    = '0;
                drain_n  = 1'b1;
            end
            DRAIN: begin
                state_n = last ? DONE : DRAIN;
                cnt_n   = cnt + 1'b1;
                cap_n   = !last && (int'(cnt) + 1 < N);
                drain_n = !last;
                done_n  = last;
                wr_n    = hist[PPU_LAT-1];
                if (cap_n) idx_n = IW'(cnt + 1'b1);
                if (wr_n) begin
                    addr_n = ptr;
                    ptr_n  = ptr + stride;
                end
            end
            default: state_n = IDLE;
        endcase
        // hist[j] remembers whether the logical cycle j steps back was a capture
        hist_n = (hist << 1) | PPU_LAT'(cap_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            hist           <= '0;
            stride         <= '0;
            ptr            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            start_err      <= 1'b0;
            drain_enable   <= 1'b0;
            ppu_capture_en <= 1'b0;
            ppu_cycle_idx  <= '0;
            ub_wr_en       <= 1'b0;
            ub_wr_addr     <= '0;
        end else begin
            if (state == DRAIN && start) start_err <= 1'b1;
            drain_enable   <= en && drain_n;
            ppu_capture_en <= en && cap_n;
            ub_wr_en       <= en && wr_n;
            done           <= en && done_n;
            if (en) begin
                state         <= state_n;
                cnt           <= cnt_n;
                hist          <= hist_n;
                stride        <= stride_n;
                ptr           <= ptr_n;
                busy          <= state_n == DRAIN;
                ppu_cycle_idx <= idx_n;
                ub_wr_addr    <= addr_n;
            end
        end
    end

`ifdef DRAIN_SEQ_AUTO_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) acc_clear <= 1'b0;
        else        acc_clear <= en && done_n;
    end
`else
    assign acc_clear = 1'b0;
`endif

endmodule
